// File: rtl/fifo_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_frame_writer
// Purpose  : Serializes framed 32-bit payloads into 8-bit async-FIFO writes
//            (SOF, length, LSB-first payload bytes, XOR checksum).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_frame_writer #(
  parameter int         WORD_W   = 32,
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int         LEN_W    = 6
) (
  input  logic              write_clk,
  input  logic              rst_l,
  input  logic              frame_valid,
  input  logic [LEN_W-1:0]  frame_len,
  output logic              frame_ready,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  input  logic              mem_full,
  output logic              write_en,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic [15:0]       frames_sent,
  output logic              len_err
);

  localparam int c_NBYTES = WORD_W / 8;
  localparam int c_IDX_W  = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LEN  = 3'd2,
    S_PAY  = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_words_acc;
  logic [WORD_W-1:0]   r_buf;
  logic                r_buf_valid;
  logic [c_IDX_W-1:0]  r_idx;
  logic [7:0]          r_csum;
  logic [15:0]         r_frames_sent;
  logic                r_len_err;

  logic                w_emit;
  logic [7:0]          w_byte;
  logic                w_last_byte;
  logic                w_words_left;
  logic                w_frame_acc;

  assign w_last_byte  = (r_idx == c_LAST_IDX);
  assign w_words_left = (r_words_acc != r_len);
  assign w_frame_acc  = frame_ready & frame_valid & (frame_len != '0);

  assign write_en    = w_emit & ~mem_full;
  assign write_data  = w_byte;
  assign busy        = (r_state != S_IDLE);
  assign frames_sent = r_frames_sent;
  assign len_err     = r_len_err;

  always_ff @(posedge write_clk or negedge rst_l) begin
    if (!rst_l) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_byte      = 8'h00;
    frame_ready = 1'b0;
    word_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        frame_ready = rst_l;
        if (w_frame_acc) w_state_nxt = S_HDR;
      end
      S_HDR: begin
        w_emit = 1'b1;
        w_byte = SOF_BYTE;
        if (!mem_full) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        w_emit     = 1'b1;
        w_byte     = 8'(r_len);
        // Prefetch the first word so PAY starts without a bubble.
        word_ready = ~r_buf_valid;
        if (!mem_full) w_state_nxt = S_PAY;
      end
      S_PAY: begin
        w_emit     = r_buf_valid;
        w_byte     = r_buf[8*r_idx +: 8];
        // Refill in the same cycle the final byte of the held word leaves.
        word_ready = w_words_left & (~r_buf_valid | (~mem_full & w_last_byte));
        if (r_buf_valid && !mem_full && w_last_byte && !w_words_left)
          w_state_nxt = S_CSUM;
      end
      S_CSUM: begin
        w_emit = 1'b1;
        w_byte = r_csum;
        if (!mem_full) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge rst_l) begin
    if (!rst_l) begin
      r_len         <= '0;
      r_words_acc   <= '0;
      r_buf         <= '0;
      r_buf_valid   <= 1'b0;
      r_idx         <= '0;
      r_csum        <= 8'h00;
      r_frames_sent <= 16'h0000;
      r_len_err     <= 1'b0;
    end else begin
      r_len_err <= frame_ready & frame_valid & (frame_len == '0);
      if (w_frame_acc) begin
        r_len       <= frame_len;
        r_words_acc <= '0;
        r_buf_valid <= 1'b0;
        r_idx       <= '0;
        r_csum      <= 8'h00;
      end
      if (write_en && (r_state == S_LEN || r_state == S_PAY))
        r_csum <= r_csum ^ write_data;
      if (write_en && r_state == S_PAY)
        r_idx <= w_last_byte ? '0 : r_idx + c_IDX_W'(1);
      if (word_valid && word_ready) begin
        r_buf       <= word_data;
        r_buf_valid <= 1'b1;
        r_words_acc <= r_words_acc + LEN_W'(1);
      end else if (write_en && r_state == S_PAY && w_last_byte) begin
        r_buf_valid <= 1'b0;
      end
      if (write_en && r_state == S_CSUM)
        r_frames_sent <= r_frames_sent + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/fifo_frame_writer.md
Name: fifo_frame_writer

Overview:
Write-side producer for the 8-bit async FIFO write port, clocked in the write_clk domain.
- Accepts frame requests (length in words) and 32-bit payload words over valid/ready handshakes.
- Serializes each frame into FIFO bytes: SOF, length, payload bytes LSB-first, XOR checksum.
- Owns all write-port flow control: never pushes while the FIFO reports full, because the FIFO occupancy counter does not self-protect.

Parameters:
WORD_W, 32, payload word width; must be a multiple of 8.
SOF_BYTE, 8'hA5, start-of-frame marker byte.
LEN_W, 6, frame_len width; max frame is 2^LEN_W-1 words.

Ports:
write_clk  in  1  write-domain clock.
rst_l  in  1  reset, asynchronous, active-low.
frame_valid  in  1  frame request valid.
frame_len  in  LEN_W  payload length in words; 0 is illegal.
frame_ready  out  1  frame request accepted when high with frame_valid.
word_valid  in  1  payload word valid.
word_data  in  WORD_W  payload word.
word_ready  out  1  payload word accepted when high with word_valid.
mem_full  in  1  FIFO full flag.
write_en  out  1  FIFO push strobe.
write_data  out  8  FIFO push data.
busy  out  1  high while a frame is in progress (state != IDLE).
frames_sent  out  16  count of completed frames; wraps.
len_err  out  1  one-cycle pulse when a zero-length request is dropped.

Behaviour:
- Reset (async, rst_l low):
  - state = IDLE; frames_sent = 0; len_err = 0; buffer empty; checksum = 0.
  - write_en = 0 combinationally; write_data = 0; word_ready = 0; frame_ready = 1 once released.
- FSM states: IDLE, HDR, LEN, PAY, CSUM.
- Push rule: write_en = emit_pending & !mem_full, evaluated combinationally each cycle.
  - write_data is driven from registers and held stable while stalled.
  - A byte is consumed only when write_en = 1.
- IDLE:
  - frame_ready = 1.
  - frame_valid with frame_len != 0: latch len, clear checksum, go to HDR.
  - frame_valid with frame_len == 0: pulse len_err the next cycle, no FIFO writes, stay in IDLE.
- HDR: emit SOF_BYTE; on push go to LEN.
- LEN:
  - Emit {0-padded frame_len} as 8 bits; checksum ^= that byte.
  - On push go to PAY.
  - word_ready = 1 in LEN (buffer is always empty here).
- PAY:
  - Single-word buffer with byte index 0..WORD_W/8-1.
  - Bytes are emitted LSB-first only while the buffer is valid; each push XORs the byte into checksum.
  - word_ready = 1 when either:
    - the buffer is empty and words_accepted < len, or
    - the final byte of the buffer is being pushed this cycle and words_accepted < len (same-cycle refill, zero bubble).
  - After the last byte of word number len is pushed, go to CSUM.
- CSUM:
  - Emit checksum = XOR of the length byte and all payload bytes.
  - On push: frames_sent += 1 (mod 2^16), go to IDLE.
- Throughput: with mem_full low and words always valid, bytes are pushed on consecutive cycles. Frame of N words = N*4+3 cycles from HDR through CSUM.
- Request handling outside IDLE:
  - frame_valid is ignored; frame_ready = 0.
  - word_valid is ignored whenever word_ready = 0.
- Stall: mem_full high in any emitting state holds state, index, buffer and write_data unchanged. No byte is lost or duplicated.
- Reset mid-frame: frame is abandoned immediately; bytes already pushed are not retracted; returns to IDLE.

Test Plan:
- Single frame: frame_len=1, word_data=0x11223344, word_valid held, mem_full=0 -> writes A5,01,44,33,22,11,45 on 7 consecutive cycles; frames_sent=1; busy low afterwards.
- Backpressure: same frame, mem_full forced high for 5 cycles after byte 0x33 -> write_en=0 and write_data=0x22 held for 5 cycles, then 22,11,45 follow; no loss.
- Zero length: frame_valid with frame_len=0 -> len_err pulse of 1 cycle, zero write_en, frames_sent unchanged, frame_ready stays 1.
- Max frame: frame_len=63, incrementing words with continuous word_valid -> 255 pushes on 255 consecutive cycles, word_ready refilled without bubble, checksum matches model.
- Word starvation: word_valid dropped for 3 cycles between words -> write_en low during the gap, byte order intact.
- Reset mid-PAY: rst_l low during byte 2 of word 3 -> write_en=0 immediately; after release state IDLE, frame_ready=1, frames_sent=0; a subsequent frame is correct.
